mod_clock_sequencer: RTL and testbench
======================================

// Module: mod_clock_sequencer
// PURPOSE
//  Sits directly downstream of the system PLL, clocked by its 21.442080 MHz master output.
//  Turns the raw PLL lock flag into a clean system reset, then generates phase-locked
//  clock enables: PPU dot (master/4 = 5.36052 MHz), CPU (master/12), APU (CPU/2), and CPU M2 phase.
//  All downstream logic runs on clk and qualifies its registers with these enables.
// PARAMETERS
//  RESET_HOLD    1024  master cycles sys_rst stays high after lock is seen stable (>=1)
//  PPU_DIV       4     master cycles per ppu_ce pulse
//  CPU_DIV       12    master cycles per cpu_ce pulse; must be a multiple of PPU_DIV
//  SYNC_STAGES   2     flops in the pll_locked synchronizer (>=2)
// PORTS
//  clk         in   1  master clock, 21.442080 MHz PLL output
//  rst         in   1  synchronous, active-high reset (external/button)
//  pll_locked  in   1  PLL lock flag, asynchronous to clk
//  sys_rst     out  1  synchronous active-high reset for downstream logic
//  ppu_ce      out  1  one-cycle pulse, every PPU_DIV cycles
//  cpu_ce      out  1  one-cycle pulse, every CPU_DIV cycles
//  apu_ce      out  1  one-cycle pulse on every 2nd cpu_ce
//  cpu_m2      out  1  CPU M2 level: high when phase cnt >= PPU_DIV
// BEHAVIOUR
//  Reset (rst=1): state=WAIT_LOCK, cnt=0, hold counter=0, apu toggle=0, sync flops=0;
//   sys_rst=1, ppu_ce=cpu_ce=apu_ce=cpu_m2=0. All outputs registered.
//  lock_s = pll_locked after SYNC_STAGES flops.
//  FSM: WAIT_LOCK -> HOLD when lock_s=1 (hold counter cleared).
//   HOLD: counter increments each cycle; lock_s=0 -> WAIT_LOCK; at RESET_HOLD-1 -> RUN.
//   RUN: lock_s=0 -> WAIT_LOCK; sys_rst reasserts next cycle, enables forced 0, cnt=0.
//  sys_rst=1 in WAIT_LOCK/HOLD, 0 in RUN; deasserts in same cycle as first RUN enables.
//  Phase counter cnt: 0..CPU_DIV-1, wraps to 0, advances only in RUN; held at 0 otherwise.
//  In RUN: ppu_ce=(cnt%PPU_DIV==0); cpu_ce=(cnt==0); apu_ce=cpu_ce & ~apu_tgl;
//   apu_tgl flips on each cpu_ce; cpu_m2=(cnt>=PPU_DIV).
//  First RUN cycle: cnt=0 -> ppu_ce=cpu_ce=apu_ce=1 together, cpu_m2=0.
//  rst has priority over everything; rst mid-RUN returns to WAIT_LOCK full reset sequence.
//  Lock glitch shorter than SYNC_STAGES cycles may be missed; longer always restarts HOLD.
// CONFIGURATION
//  CLKSEQ_STEP_EN defined: adds ports dbg_halt in 1, dbg_step in 1, dbg_halted out 1.
//   dbg_halt sampled only when cnt==0 in RUN: if 1, cnt freezes at 0, all *_ce=0, cpu_m2=0,
//   dbg_halted=1. A rising edge of dbg_step (registered edge detect) while halted releases
//   exactly one CPU period (CPU_DIV cycles, normal pulses incl. cpu_ce), then re-halts if
//   dbg_halt still 1. Halt never splits a CPU cycle. Reset: dbg_halted=0, step edge reg=0.
//  Not defined: ports absent, counter free-runs in RUN.
// STRUCTURE
//  Package mod_clk_pkg: state enum (WAIT_LOCK, HOLD, RUN), PPU_DIV/CPU_DIV defaults,
//   $clog2-based width localparams shared with consumers of the enables.
//  Sub-module mod_sync_bit: SYNC_STAGES-deep 1-bit synchronizer for pll_locked, sync reset.
//  Elaboration check: CPU_DIV % PPU_DIV != 0 or RESET_HOLD==0 -> $error.
// TESTING
//  rst=1 5 cycles, pll_locked=0 -> sys_rst=1, all ce/m2=0, FSM in WAIT_LOCK indefinitely.
//  pll_locked 0->1 (RESET_HOLD=16) -> sys_rst falls exactly 2+16 cycles later; same
//   cycle ppu_ce=cpu_ce=apu_ce=1.
//  RUN 48 cycles -> ppu_ce 12 pulses at 4-cycle spacing, cpu_ce 4, apu_ce 2, cpu_m2 high 8/12.
//  Drop pll_locked for 5 cycles mid-RUN -> sys_rst=1 within 3 cycles, enables 0, full
//   HOLD repeats after relock; drop for 1 cycle between edges -> no glitch on outputs.
//  rst pulse mid-HOLD and mid-RUN -> state WAIT_LOCK, cnt=0, same reset values as power-up.
//  CLKSEQ_STEP_EN: dbg_halt=1 at cnt=5 -> halts at next cnt=0; 3 dbg_step pulses ->
//   exactly 3 cpu_ce, 9 ppu_ce; dbg_step held high -> only 1 period.

Source files
------------

// File: rtl/mod_clock_sequencer_pkg.sv
// Shared types and defaults for the master-clock sequencer and consumers of its clock enables.
package mod_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    HOLD,
    RUN
  } clk_state_e;

  localparam int unsigned PPU_DIV_DEF = 4;
  localparam int unsigned CPU_DIV_DEF = 12;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned PHASE_W = cnt_width(CPU_DIV_DEF);

endpackage

// File: rtl/mod_clock_sequencer_if.sv
// Clock-enable bundle from the sequencer; debug step ports exist only with CLKSEQ_STEP_EN.
interface mod_clock_sequencer_if;
  logic sys_rst;
  logic ppu_ce;
  logic cpu_ce;
  logic apu_ce;
  logic cpu_m2;
`ifdef CLKSEQ_STEP_EN
  logic dbg_halt;
  logic dbg_step;
  logic dbg_halted;

  modport master (output sys_rst, ppu_ce, cpu_ce, apu_ce, cpu_m2, dbg_halted,
                  input dbg_halt, dbg_step);
  modport slave  (input sys_rst, ppu_ce, cpu_ce, apu_ce, cpu_m2, dbg_halted,
                  output dbg_halt, dbg_step);
`else
  modport master (output sys_rst, ppu_ce, cpu_ce, apu_ce, cpu_m2);
  modport slave  (input sys_rst, ppu_ce, cpu_ce, apu_ce, cpu_m2);
`endif
endinterface

// File: rtl/mod_clock_sequencer_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level, synchronous reset to 0.
module mod_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];
endmodule

// File: rtl/mod_clock_sequencer.sv
// PLL-lock reset sequencer and PPU/CPU/APU clock-enable generator.
// Optional single-step debug halt enabled by defining CLKSEQ_STEP_EN.
module mod_clock_sequencer
  import mod_clk_pkg::*;
#(
  parameter int unsigned RESET_HOLD  = 1024,
  parameter int unsigned PPU_DIV     = PPU_DIV_DEF,
  parameter int unsigned CPU_DIV     = CPU_DIV_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
  mod_clock_sequencer_if.master ce_if
);
  localparam int unsigned CW = cnt_width(CPU_DIV);
  localparam int unsigned HW = cnt_width(RESET_HOLD);

  if ((CPU_DIV % PPU_DIV) != 0 || RESET_HOLD == 0 || SYNC_STAGES < 2) begin : g_bad_cfg
    $error("mod_clock_sequencer: illegal CPU_DIV/PPU_DIV/RESET_HOLD/SYNC_STAGES");
  end

  clk_state_e    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic          apu_tgl, apu_tgl_n;
  logic          lock_s;
  logic          pulse_en;
  logic          cpu_ce_n;
`ifdef CLKSEQ_STEP_EN
  logic          halted, halted_n;
  logic          step_q;
  logic          step_rise;

  assign step_rise = ce_if.dbg_step & ~step_q;
`endif

  mod_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  // Outputs are registered decodes of the next state/phase, so sys_rst drops
  // on the same edge that presents the first cnt=0 pulses.
  always_comb begin
    state_n  = state;
    hcnt_n   = '0;
    cnt_n    = '0;
    pulse_en = 1'b0;
`ifdef CLKSEQ_STEP_EN
    halted_n = 1'b0;
`endif
    unique case (state)
      WAIT_LOCK: if (lock_s) state_n = HOLD;
      HOLD: begin
        if (!lock_s) state_n = WAIT_LOCK;
        else if (hcnt == HW'(RESET_HOLD - 1)) begin
          state_n  = RUN;
          pulse_en = 1'b1;
        end else hcnt_n = hcnt + 1'b1;
      end
      RUN: begin
        if (!lock_s) state_n = WAIT_LOCK;
        else begin
          pulse_en = 1'b1;
          if (cnt != CW'(CPU_DIV - 1)) cnt_n = cnt + 1'b1;
`ifdef CLKSEQ_STEP_EN
          if (halted) begin
            // Parked at phase 0; a step edge replays phase 0 with its pulses.
            cnt_n    = '0;
            pulse_en = step_rise;
            halted_n = ~step_rise;
          end else if (cnt == CW'(CPU_DIV - 1) && ce_if.dbg_halt) begin
            pulse_en = 1'b0;
            halted_n = 1'b1;
          end
`endif
        end
      end
      default: state_n = WAIT_LOCK;
    endcase

    cpu_ce_n  = pulse_en && (cnt_n == '0);
    apu_tgl_n = (state_n == RUN) ? (apu_tgl ^ cpu_ce_n) : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WAIT_LOCK;
      cnt           <= '0;
      hcnt          <= '0;
      apu_tgl       <= 1'b0;
      ce_if.sys_rst <= 1'b1;
      ce_if.ppu_ce  <= 1'b0;
      ce_if.cpu_ce  <= 1'b0;
      ce_if.apu_ce  <= 1'b0;
      ce_if.cpu_m2  <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      hcnt          <= hcnt_n;
      apu_tgl       <= apu_tgl_n;
      ce_if.sys_rst <= (state_n != RUN);
      ce_if.ppu_ce  <= pulse_en && ((32'(cnt_n) % PPU_DIV) == 0);
      ce_if.cpu_ce  <= cpu_ce_n;
      ce_if.apu_ce  <= cpu_ce_n & ~apu_tgl;
      ce_if.cpu_m2  <= pulse_en && (32'(cnt_n) >= PPU_DIV);
    end
  end

`ifdef CLKSEQ_STEP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      halted <= 1'b0;
      step_q <= 1'b0;
    end else begin
      halted <= halted_n;
      step_q <= ce_if.dbg_step;
    end
  end

  assign ce_if.dbg_halted = halted;
`endif
endmodule

// File: tb/tb_mod_clock_sequencer.sv
// Directed self-checking bench for mod_clock_sequencer (RESET_HOLD=16, 4/12 dividers).
module tb_mod_clock_sequencer;
  import mod_clk_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic pll_locked;
  int   vectors = 0;
  int   miscompares = 0;

  mod_clock_sequencer_if ce_if ();

  mod_clock_sequencer #(.RESET_HOLD(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .ce_if      (ce_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".sys_rst"}, 32'(ce_if.sys_rst), 1);
    chk({tag, ".ppu_ce"},  32'(ce_if.ppu_ce), 0);
    chk({tag, ".cpu_ce"},  32'(ce_if.cpu_ce), 0);
    chk({tag, ".apu_ce"},  32'(ce_if.apu_ce), 0);
    chk({tag, ".cpu_m2"},  32'(ce_if.cpu_m2), 0);
  endtask

  // ph counts cycles since the first RUN cycle (phase 0, apu toggle clear).
  task automatic chk_run(input int ph);
    chk("run.sys_rst", 32'(ce_if.sys_rst), 0);
    chk("run.ppu_ce",  32'(ce_if.ppu_ce), 32'(ph % 4 == 0));
    chk("run.cpu_ce",  32'(ce_if.cpu_ce), 32'(ph % 12 == 0));
    chk("run.apu_ce",  32'(ce_if.apu_ce), 32'(ph % 24 == 0));
    chk("run.cpu_m2",  32'(ce_if.cpu_m2), 32'(ph % 12 >= 4));
  endtask

  // pll_locked is high and first sampled at the next edge: 2 sync + 16 hold
  // cycles keep sys_rst high, the 19th edge starts RUN.
  task automatic relock_check(input string tag);
    for (int k = 1; k <= 18; k++) begin
      tick();
      chk({tag, ".hold_sys_rst"}, 32'(ce_if.sys_rst), 1);
      chk({tag, ".hold_ppu_ce"},  32'(ce_if.ppu_ce), 0);
    end
    tick();
    chk_run(0);
  endtask

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
`ifdef CLKSEQ_STEP_EN
    ce_if.dbg_halt = 1'b0;
    ce_if.dbg_step = 1'b0;
`endif
    repeat (5) tick();
    chk_idle("reset");
    chk("reset.state", 32'(dut.state), 32'(WAIT_LOCK));
    rst = 1'b0;

    repeat (20) begin
      tick();
      chk_idle("nolock");
    end
    chk("nolock.state", 32'(dut.state), 32'(WAIT_LOCK));

    pll_locked = 1'b1;
    relock_check("lock1");
    for (int ph = 1; ph < 48; ph++) begin
      tick();
      chk_run(ph);
    end

    // Lock loss: two more RUN cycles pass through the synchronizer first.
    pll_locked = 1'b0;
    tick(); chk_run(48);
    tick(); chk_run(49);
    tick(); chk_idle("drop3");
    chk("drop.state", 32'(dut.state), 32'(WAIT_LOCK));
    tick(); chk_idle("drop4");
    tick(); chk_idle("drop5");
    pll_locked = 1'b1;
    relock_check("lock2");
    for (int ph = 1; ph <= 10; ph++) begin
      tick();
      chk_run(ph);
    end

    pll_locked = 1'b0;
    #3;
    pll_locked = 1'b1;
    for (int ph = 11; ph <= 34; ph++) begin
      tick();
      chk_run(ph);
    end

    pll_locked = 1'b0;
    repeat (5) tick();
    pll_locked = 1'b1;
    repeat (10) tick();
    chk("midhold.state", 32'(dut.state), 32'(HOLD));
    rst = 1'b1;
    tick();
    chk_idle("rst_hold");
    chk("rst_hold.state", 32'(dut.state), 32'(WAIT_LOCK));
    chk("rst_hold.cnt", 32'(dut.cnt), 0);
    chk("rst_hold.hcnt", 32'(dut.hcnt), 0);
    rst = 1'b0;
    relock_check("lock3");

    for (int ph = 1; ph <= 7; ph++) begin
      tick();
      chk_run(ph);
    end
    rst = 1'b1;
    tick();
    chk_idle("rst_run");
    chk("rst_run.state", 32'(dut.state), 32'(WAIT_LOCK));
    chk("rst_run.cnt", 32'(dut.cnt), 0);
    chk("rst_run.apu_tgl", 32'(dut.apu_tgl), 0);
    rst = 1'b0;
    relock_check("lock4");

`ifdef CLKSEQ_STEP_EN
    begin
      int nc;
      int np;
      for (int ph = 1; ph <= 5; ph++) begin
        tick();
        chk_run(ph);
      end
      ce_if.dbg_halt = 1'b1;
      for (int ph = 6; ph <= 11; ph++) begin
        tick();
        chk_run(ph);
      end
      tick();
      chk("halt.dbg_halted", 32'(ce_if.dbg_halted), 1);
      chk("halt.cpu_ce", 32'(ce_if.cpu_ce), 0);
      chk("halt.ppu_ce", 32'(ce_if.ppu_ce), 0);
      chk("halt.cnt", 32'(dut.cnt), 0);
      nc = 0;
      np = 0;
      repeat (5) begin
        tick();
        nc += int'(ce_if.cpu_ce);
        np += int'(ce_if.ppu_ce);
      end
      chk("halt.idle_cpu", 32'(nc), 0);
      for (int s = 0; s < 3; s++) begin
        ce_if.dbg_step = 1'b1;
        tick();
        nc += int'(ce_if.cpu_ce);
        np += int'(ce_if.ppu_ce);
        ce_if.dbg_step = 1'b0;
        repeat (19) begin
          tick();
          nc += int'(ce_if.cpu_ce);
          np += int'(ce_if.ppu_ce);
        end
      end
      chk("step3.cpu_ce", 32'(nc), 3);
      chk("step3.ppu_ce", 32'(np), 9);
      chk("step3.dbg_halted", 32'(ce_if.dbg_halted), 1);
      nc = 0;
      np = 0;
      ce_if.dbg_step = 1'b1;
      repeat (40) begin
        tick();
        nc += int'(ce_if.cpu_ce);
        np += int'(ce_if.ppu_ce);
      end
      ce_if.dbg_step = 1'b0;
      chk("held.cpu_ce", 32'(nc), 1);
      chk("held.ppu_ce", 32'(np), 3);
      chk("held.dbg_halted", 32'(ce_if.dbg_halted), 1);
      ce_if.dbg_halt = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
